// File: rtl/spsram_fifo_ctrl_if.sv
// Push/pop stream bundle between a producer/consumer pair and the SRAM FIFO controller.
interface spsram_fifo_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;

  // master: the streaming environment; slave: the FIFO controller
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/spsram_fifo_ctrl.sv
// FIFO controller mastering a single-port SRAM with a registered read stage;
// all RAM accesses are serialised through one state machine.
module spsram_fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  spsram_fifo_ctrl_if.slave     strm,
  output logic [ADDR_WIDTH:0]   ram_level,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  localparam int unsigned LW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [LW-1:0]         LVL_FULL = LW'(RAM_DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, READ, READ_CAP} state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_nx, rd_ptr, rd_ptr_nx, addr_nx;
  logic [LW-1:0]         level_nx;
  logic [DATA_WIDTH-1:0] hold, hold_nx, out_data_nx;
  logic                  out_valid_nx, in_ready_nx;
  logic                  cs_nx, we_nx, oe_nx;

  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : ADDR_WIDTH'(p + 1'b1);
  endfunction

  // The write-hold register owns the bus only while a write is in progress.
  assign ram_data = ram_we ? hold : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      ram_level     <= '0;
      hold          <= '0;
      strm.in_ready <= 1'b1;
      strm.out_valid <= 1'b0;
      strm.out_data <= '0;
      ram_addr      <= '0;
      ram_cs        <= 1'b0;
      ram_we        <= 1'b0;
      ram_oe        <= 1'b0;
    end else begin
      state         <= state_nx;
      wr_ptr        <= wr_ptr_nx;
      rd_ptr        <= rd_ptr_nx;
      ram_level     <= level_nx;
      hold          <= hold_nx;
      strm.in_ready <= in_ready_nx;
      strm.out_valid <= out_valid_nx;
      strm.out_data <= out_data_nx;
      ram_addr      <= addr_nx;
      ram_cs        <= cs_nx;
      ram_we        <= we_nx;
      ram_oe        <= oe_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    wr_ptr_nx    = wr_ptr;
    rd_ptr_nx    = rd_ptr;
    level_nx     = ram_level;
    hold_nx      = hold;
    out_valid_nx = strm.out_valid & ~strm.out_ready;
    out_data_nx  = strm.out_data;

    case (state)
      IDLE: begin
        // Refilling an empty output register wins over accepting a push.
        if (!strm.out_valid && (ram_level != '0)) begin
          state_nx = READ;
          level_nx = LW'(ram_level - 1'b1);
        end else if (strm.in_ready && strm.in_valid) begin
          state_nx = WRITE;
          hold_nx  = strm.in_data;
          level_nx = LW'(ram_level + 1'b1);
        end
      end
      WRITE: begin
        wr_ptr_nx = ptr_inc(wr_ptr);
        state_nx  = IDLE;
      end
      READ: state_nx = READ_CAP;
      READ_CAP: begin
        out_data_nx  = ram_data;
        out_valid_nx = 1'b1;
        rd_ptr_nx    = ptr_inc(rd_ptr);
        state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // Bus controls and in_ready are registered from the next-state values.
    cs_nx = (state_nx != IDLE);
    we_nx = (state_nx == WRITE);
    oe_nx = (state_nx == READ) || (state_nx == READ_CAP);
    if (state_nx == WRITE)
      addr_nx = wr_ptr_nx;
    else if (oe_nx)
      addr_nx = rd_ptr_nx;
    else
      addr_nx = ram_addr;

    in_ready_nx = (state_nx == IDLE) && (out_valid_nx || (level_nx == '0)) &&
                  (level_nx < LVL_FULL);
  end

endmodule
